display_scan_scheduler: RTL and testbench

// Sequences the 4-digit 7-segment display: time-multiplexes the anodes off
// the clock-divider tick, inserts blanking dead-time between digits against

---
 rtl/display_scan_scheduler_if.sv | 22 ++
 rtl/display_scan_scheduler.sv | 127 ++++++++++++
 tb/tb_display_scan_scheduler.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_scheduler_if.sv
// Bundle between the display scan scheduler and its environment: tick and page
// sources in, anode/digit/blank/page-select out.
interface display_scan_scheduler_if;
    logic        tick_i;
    logic [15:0] page_a_i;
    logic [15:0] page_b_i;
    logic        page_hold_i;
    logic [3:0]  an_o;
    logic [3:0]  digit_o;
    logic        blank_o;
    logic        page_sel_o;

    modport master (
        output tick_i, page_a_i, page_b_i, page_hold_i,
        input  an_o, digit_o, blank_o, page_sel_o
    );

    modport slave (
        input  tick_i, page_a_i, page_b_i, page_hold_i,
        output an_o, digit_o, blank_o, page_sel_o
    );
endinterface

// File: rtl/display_scan_scheduler.sv
// 4-digit 7-segment scan sequencer: per-digit drive/blank dead-time, leading-zero
// suppression and frame-synchronous rotation between two 16-bit pages.
module display_scan_scheduler #(
    parameter int unsigned DRIVE_TICKS = 4,
    parameter int unsigned BLANK_TICKS = 1,
    parameter int unsigned PAGE_FRAMES = 256,
    parameter bit          LZ_BLANK    = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    display_scan_scheduler_if.slave  bus
);
    localparam int unsigned CNT_MAX = (DRIVE_TICKS > BLANK_TICKS) ? DRIVE_TICKS : BLANK_TICKS;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned FRM_W   = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;

    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_TICKS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(PAGE_FRAMES - 1);

    typedef enum logic {
        ST_DRIVE = 1'b0,
        ST_BLANK = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [FRM_W-1:0] frame_q, frame_d;
    logic             page_sel_q, page_sel_d;
    logic [15:0]      snap_q, snap_d;
    logic [3:0]       an_q, an_d;
    logic [3:0]       digit_q, digit_d;
    logic             blank_q, blank_d;
    logic             suppress_c;

    // State register; outputs are registered alongside the state they decode from.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_BLANK;
            idx_q      <= 2'd3;
            cnt_q      <= BLANK_LAST;
            frame_q    <= '0;
            page_sel_q <= 1'b0;
            snap_q     <= 16'h0000;
            an_q       <= 4'b1111;
            digit_q    <= 4'h0;
            blank_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            page_sel_q <= page_sel_d;
            snap_q     <= snap_d;
            an_q       <= an_d;
            digit_q    <= digit_d;
            blank_q    <= blank_d;
        end
    end

    // Next-state and next-output logic; outputs decode from the next state so
    // they change on the same tick as the scan position.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        frame_d    = frame_q;
        page_sel_d = page_sel_q;
        snap_d     = snap_q;
        an_d       = 4'b1111;
        digit_d    = 4'h0;
        blank_d    = 1'b1;
        suppress_c = 1'b0;

        if (bus.tick_i) begin
            unique case (state_q)
                ST_DRIVE: begin
                    if (cnt_q == DRIVE_LAST) begin
                        state_d = ST_BLANK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_DRIVE;
                        cnt_d   = '0;
                        idx_d   = idx_q + 2'd1;
                        // Wrapping to digit 0 is the frame start: rotate pages and snapshot.
                        if (idx_q == 2'd3) begin
                            if (frame_q == FRM_LAST) begin
                                frame_d = '0;
                                if (!bus.page_hold_i) begin
                                    page_sel_d = ~page_sel_q;
                                end
                            end else begin
                                frame_d = frame_q + FRM_W'(1);
                            end
                            snap_d = page_sel_d ? bus.page_b_i : bus.page_a_i;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_BLANK;
                end
            endcase
        end

        // A digit is a leading zero when it and every nibble above it are zero.
        suppress_c = LZ_BLANK && (idx_d != 2'd0) && ((snap_d >> {idx_d, 2'b00}) == 16'h0000);

        if ((state_d == ST_DRIVE) && !suppress_c) begin
            an_d    = ~(4'b0001 << idx_d);
            digit_d = snap_d[{idx_d, 2'b00} +: 4];
            blank_d = 1'b0;
        end
    end

    assign bus.an_o       = an_q;
    assign bus.digit_o    = digit_q;
    assign bus.blank_o    = blank_q;
    assign bus.page_sel_o = page_sel_q;
endmodule

// File: tb/tb_display_scan_scheduler.sv
// Scoreboard bench for display_scan_scheduler (PAGE_FRAMES=2, other defaults).
module tb_display_scan_scheduler;
    localparam int FRAME = 20;
    localparam int SLOT  = 5;
    localparam int DRV   = 4;
    localparam int PF    = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [3:0] digit;
        logic       blank;
        logic       sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    exp_t        sb_q[$];
    exp_t        last_exp;
    exp_t        e;
    exp_t        got;
    int          mt;
    int          m_fcnt;
    logic        m_sel;
    logic [15:0] m_snap;

    display_scan_scheduler_if bus ();

    display_scan_scheduler #(
        .PAGE_FRAMES(PF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mt       = 0;
        m_fcnt   = 0;
        m_sel    = 1'b0;
        m_snap   = 16'h0000;
        last_exp = '{an: 4'hF, digit: 4'h0, blank: 1'b1, sel: 1'b0};
    endtask

    // Model is positional: tick count since reset gives frame slot and phase.
    task automatic advance();
        int   p;
        int   slot;
        exp_t n;
        if (bus.tick_i) begin
            mt++;
            p = (mt - 1) % FRAME;
            if (p == 0) begin
                if (m_fcnt == PF - 1) begin
                    m_fcnt = 0;
                    if (!bus.page_hold_i) m_sel = ~m_sel;
                end else begin
                    m_fcnt++;
                end
                m_snap = m_sel ? bus.page_b_i : bus.page_a_i;
            end
            slot = p / SLOT;
            n = '{an: 4'hF, digit: 4'h0, blank: 1'b1, sel: m_sel};
            if ((p % SLOT) < DRV && !(slot != 0 && (m_snap >> (4 * slot)) == 16'h0)) begin
                n.an    = ~(4'h1 << slot);
                n.digit = m_snap[4*slot +: 4];
                n.blank = 1'b0;
            end
            last_exp = n;
        end
        sb_q.push_back(last_exp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.tick_i = 1'b1;
        rst_n = 1'b0;
        #1;
        got = {bus.an_o, bus.digit_o, bus.blank_o, bus.page_sel_o};
        total++;
        if (got !== 10'b1111_0000_1_0) begin
            bad++;
            $display("FAIL reset_async got=%b exp=%b", got, 10'b1111_0000_1_0);
        end
        repeat (3) @(posedge clk);
        #1;
        got = {bus.an_o, bus.digit_o, bus.blank_o, bus.page_sel_o};
        total++;
        if (got !== 10'b1111_0000_1_0) begin
            bad++;
            $display("FAIL reset_held got=%b exp=%b", got, 10'b1111_0000_1_0);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_scan();
        bus.page_a_i = 16'h1234;
        bus.page_b_i = 16'h1234;
        for (int i = 0; i < 45; i++) begin
            advance();
            e = sb_q.pop_front();
            got = {bus.an_o, bus.digit_o, bus.blank_o, bus.page_sel_o};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL scan[%0d] got=%b exp=%b", i, got, e);
            end
            if (i == 0) begin
                total++;
                if (bus.an_o !== 4'b1110 || bus.digit_o !== 4'h4) begin
                    bad++;
                    $display("FAIL scan_first got an=%b digit=%h exp an=1110 digit=4", bus.an_o, bus.digit_o);
                end
            end
        end
    endtask

    task automatic test_lz();
        logic [15:0] pats [2];
        pats[0] = 16'h0005;
        pats[1] = 16'h0000;
        for (int k = 0; k < 2; k++) begin
            bus.page_a_i = pats[k];
            bus.page_b_i = pats[k];
            for (int i = 0; i < 60; i++) begin
                advance();
                e = sb_q.pop_front();
                got = {bus.an_o, bus.digit_o, bus.blank_o, bus.page_sel_o};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL lz%0d[%0d] got=%b exp=%b", k, i, got, e);
                end
                if (i >= 20 && bus.an_o !== 4'b1110 && bus.an_o !== 4'b1111) begin
                    total++;
                    bad++;
                    $display("FAIL lz_anode got an=%b exp 1110 or 1111", bus.an_o);
                end
            end
        end
    endtask

    task automatic test_rotation();
        logic prev;
        bus.page_a_i = 16'hAAAA;
        bus.page_b_i = 16'hBBBB;
        prev = bus.page_sel_o;
        for (int i = 0; i < 130; i++) begin
            advance();
            e = sb_q.pop_front();
            got = {bus.an_o, bus.digit_o, bus.blank_o, bus.page_sel_o};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL rot[%0d] got=%b exp=%b", i, got, e);
            end
            if (bus.page_sel_o !== prev) begin
                total++;
                if (bus.an_o !== 4'b1110 || bus.digit_o !== (bus.page_sel_o ? 4'hB : 4'hA)) begin
                    bad++;
                    $display("FAIL rot_edge got an=%b digit=%h sel=%b", bus.an_o, bus.digit_o, bus.page_sel_o);
                end
            end
            prev = bus.page_sel_o;
        end
    endtask

    task automatic test_midframe();
        bus.page_a_i = 16'h1111;
        bus.page_b_i = 16'h1111;
        for (int i = 0; i < FRAME && (mt % FRAME) != 0; i++) begin
            advance();
            e = sb_q.pop_front();
            got = {bus.an_o, bus.digit_o, bus.blank_o, bus.page_sel_o};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL mid_align[%0d] got=%b exp=%b", i, got, e);
            end
        end
        for (int i = 0; i < 40; i++) begin
            if (i == 7) begin
                bus.page_a_i = 16'h2222;
                bus.page_b_i = 16'h2222;
            end
            advance();
            e = sb_q.pop_front();
            got = {bus.an_o, bus.digit_o, bus.blank_o, bus.page_sel_o};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL mid[%0d] got=%b exp=%b", i, got, e);
            end
            if (i == 15 || i == 30) begin
                total++;
                if (bus.digit_o !== ((i == 15) ? 4'h1 : 4'h2)) begin
                    bad++;
                    $display("FAIL mid_digit[%0d] got=%h", i, bus.digit_o);
                end
            end
        end
    endtask

    task automatic test_hold();
        logic s0;
        bus.page_a_i = 16'hAAAA;
        bus.page_b_i = 16'hBBBB;
        bus.page_hold_i = 1'b1;
        s0 = bus.page_sel_o;
        for (int i = 0; i < 100; i++) begin
            advance();
            e = sb_q.pop_front();
            got = {bus.an_o, bus.digit_o, bus.blank_o, bus.page_sel_o};
            total++;
            if (got !== e || bus.page_sel_o !== s0) begin
                bad++;
                $display("FAIL hold[%0d] got=%b exp=%b sel0=%b", i, got, e, s0);
            end
        end
        bus.page_hold_i = 1'b0;
        for (int i = 0; i < 100; i++) begin
            advance();
            e = sb_q.pop_front();
            got = {bus.an_o, bus.digit_o, bus.blank_o, bus.page_sel_o};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL release[%0d] got=%b exp=%b", i, got, e);
            end
        end
    endtask

    task automatic test_tick_gaps();
        for (int i = 0; i < 200; i++) begin
            bus.tick_i = 1'($urandom_range(0, 1));
            bus.page_a_i = 16'($urandom());
            bus.page_b_i = 16'($urandom());
            advance();
            e = sb_q.pop_front();
            got = {bus.an_o, bus.digit_o, bus.blank_o, bus.page_sel_o};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL gaps[%0d] got=%b exp=%b", i, got, e);
            end
        end
        bus.tick_i = 1'b1;
    endtask

    task automatic test_midreset();
        bus.page_a_i = 16'h1234;
        bus.page_b_i = 16'h5678;
        for (int i = 0; i < 2 * FRAME && last_exp.an !== 4'b1011; i++) begin
            advance();
            e = sb_q.pop_front();
            got = {bus.an_o, bus.digit_o, bus.blank_o, bus.page_sel_o};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL mrst_run[%0d] got=%b exp=%b", i, got, e);
            end
        end
        total++;
        if (bus.an_o !== 4'b1011) begin
            bad++;
            $display("FAIL mrst_reach got an=%b exp 1011", bus.an_o);
        end
        rst_n = 1'b0;
        #1;
        got = {bus.an_o, bus.digit_o, bus.blank_o, bus.page_sel_o};
        total++;
        if (got !== 10'b1111_0000_1_0) begin
            bad++;
            $display("FAIL mrst_async got=%b exp=%b", got, 10'b1111_0000_1_0);
        end
        #2;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 25; i++) begin
            advance();
            e = sb_q.pop_front();
            got = {bus.an_o, bus.digit_o, bus.blank_o, bus.page_sel_o};
            total++;
            if (got !== e) begin
                bad++;
                $display("FAIL mrst_after[%0d] got=%b exp=%b", i, got, e);
            end
            if (i == 0) begin
                total++;
                if (bus.an_o !== 4'b1110 || bus.digit_o !== 4'h4 || bus.page_sel_o !== 1'b0) begin
                    bad++;
                    $display("FAIL mrst_first got an=%b digit=%h sel=%b exp 1110/4/0",
                             bus.an_o, bus.digit_o, bus.page_sel_o);
                end
            end
        end
    endtask

    initial begin
        bus.tick_i      = 1'b0;
        bus.page_a_i    = 16'h0000;
        bus.page_b_i    = 16'h0000;
        bus.page_hold_i = 1'b0;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_scan();
        test_lz();
        test_rotation();
        test_midframe();
        test_hold();
        test_tick_gaps();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
